data_resp_stall: RTL
====================

# data_resp_stall

Data-side bus responder for core testbenches: the memory end of the core's req/gnt/rvalid data interface. It accepts load/store transactions into an internal word RAM, withholds grant for a programmable number of cycles, and returns in-order responses after a programmable latency. It sits between the core's data port and nothing else, replacing the zero-wait RAM when the bench must stress the load/store unit's handshake and outstanding-transaction logic.

## Interface
- MEM_ADDR_WIDTH, 14: word-address width of the internal RAM, which holds 2^MEM_ADDR_WIDTH 32-bit words.
- DEPTH, 4: maximum number of outstanding (granted, not yet responded) transactions; power of two, ≥2.
- clk_i  in  1  sole clock; all state is updated on the rising edge.
- rst_i  in  1  reset, synchronous active-high.
- req_i  in  1  request from the core; held with stable payload until gnt_o.
- addr_i  in  32  byte address; bits [MEM_ADDR_WIDTH+1:2] index the RAM, and all other bits are ignored.
- we_i  in  1  1 = store, 0 = load.
- be_i  in  4  byte enables for stores.
- wdata_i  in  32  store data.
- gnt_o  out  1  grant; a transaction is accepted in any cycle with req_i && gnt_o.
- rvalid_o  out  1  one-cycle response strobe, one per accepted transaction.
- rdata_o  out  32  load data, valid with rvalid_o; 0 for stores.
- gnt_stall_i  in  4  grant wait states, sampled when the stall counter loads.
- rvalid_lat_i  in  4  extra response latency, sampled at acceptance.
- outstanding_o  out  $clog2(DEPTH)+1  current FIFO occupancy (debug).

## Operation
- Stall counter:
  - Loads gnt_stall_i on any cycle where req_i is low or a transaction is accepted.
  - Decrements while req_i is high and the count is nonzero.
- Grant:
  - gnt_o = req_i && (stall count == 0) && (occupancy < DEPTH), combinational.
  - With gnt_stall_i = 0, gnt_o rises in the same cycle as req_i.
- Acceptance, at the edge ending cycle T:
  - Store: bytes enabled by be_i are written to the RAM.
  - Load: the addressed word is read.
  - The entry {rdata (0 for stores), countdown = rvalid_lat_i} is pushed into the response FIFO.
- Response FIFO:
  - Every entry's countdown decrements each cycle, saturating at 0.
  - The head pops when its countdown is 0, driving rvalid_o/rdata_o registered in the next cycle.
  - Responses are strictly in order, at most one per cycle.
  - Nominal response cycle: T+1+L, where L is the sampled rvalid_lat_i; later if the previous response is still pending.
- Full FIFO: gnt_o is held low even if the stall count is 0. Occupancy uses the registered count, so a pop in the same cycle does not free a slot until the next cycle.
- Simultaneous push and pop: both happen and occupancy is unchanged.
- Load after a store to the same word: the load observes the stored data (RAM write at acceptance precedes any later read).
- Reset (rst_i high at an edge), including mid-operation:
  - FIFO is flushed, pending responses are dropped, and the stall counter is loaded with gnt_stall_i.
  - gnt_o, rvalid_o, rdata_o and outstanding_o are 0 at reset.
  - RAM contents are retained.
  - While rst_i is high, gnt_o is forced 0.

## Timing
- Minimum request-to-grant latency is 0 cycles; maximum is gnt_stall_i cycles plus FIFO-full wait.
- Minimum grant-to-rvalid latency is 1 cycle (L = 0).
- Back-to-back with gnt_stall_i = 0 and rvalid_lat_i = 0: one transaction per cycle, sustained, with occupancy ≤1.
- Outputs rvalid_o, rdata_o and outstanding_o are registered; gnt_o is combinational from req_i and registered state.
- The RAM has a single port: one read or write per cycle, at acceptance only.

## Configuration
- DATA_RESP_LFSR_STALL_EN defined:
  - The stall-counter load value is lfsr[3:0] & gnt_stall_i, giving pseudo-random wait states bounded by gnt_stall_i.
  - The LFSR is 16-bit maximal-length, seeded to 16'hACE1 on reset, and advances every cycle.
- Undefined: the load value is exactly gnt_stall_i, the LFSR is absent, and timing is fully deterministic.

## Structure
- Package data_resp_pkg:
  - Response-entry struct typedef {logic [31:0] rdata; logic [3:0] cnt}.
  - LFSR seed and tap constants.
- Sub-module data_resp_fifo:
  - DEPTH-entry circular FIFO of entries with per-entry saturating countdown.
  - Push/pop ports, head_ready (head countdown == 0), full, occupancy.
- The top level holds the RAM, stall counter, grant logic, optional LFSR and output registers.

## Test plan
- Store 32'hDEADBEEF at 0x100 with be=4'hF, then load 0x100; gnt_stall=0, lat=0 → both granted in the request cycle, rvalid one cycle after each grant, load rdata=32'hDEADBEEF.
- Byte store wdata=32'h000000AA, be=4'b0001 to a word holding 32'h11223344, then load → rdata=32'h112233AA.
- gnt_stall=3, single load → gnt_o rises exactly 3 cycles after req_i rises, and payload is held stable throughout.
- DEPTH=4, lat=15, 6 back-to-back loads → first 4 granted on consecutive cycles, gnt_o low until the first pop; responses return in order, each 16 cycles after its grant or 1 cycle after the previous response.
- Varying lat per transaction (5 then 0) → second response is not earlier than the cycle after the first; order is preserved.
- rst_i asserted with 3 outstanding → next cycle rvalid_o=0 and outstanding_o=0, no stale rvalid after release, and previously stored RAM data is still readable.

Source files
------------

// File: rtl/data_resp_pkg.sv
// Shared types and constants for the data-side stall responder: the response-FIFO
// entry, the LFSR seed/taps and a saturating countdown helper.
package data_resp_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  cnt;
  } resp_entry_t;

  // x^16 + x^14 + x^13 + x^11 + 1, maximal length
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [3:0] cnt_dec(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

endpackage

// File: rtl/data_resp_if.sv
// Core data-port handshake (req/gnt/rvalid); master = core, slave = memory responder.
interface data_resp_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (output req_i, addr_i, we_i, be_i, wdata_i,
                  input  gnt_o, rvalid_o, rdata_o);
  modport slave  (input  req_i, addr_i, we_i, be_i, wdata_i,
                  output gnt_o, rvalid_o, rdata_o);
endinterface

// File: rtl/data_resp_fifo.sv
// In-order response FIFO; every entry carries a countdown that saturates at 0,
// and the head may leave only once its countdown has expired.
module data_resp_fifo
  import data_resp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  resp_entry_t            push_entry,
  input  logic                   pop,
  output logic [31:0]            head_rdata,
  output logic                   head_ready,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  resp_entry_t   slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; the pointers and count alone decide which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      slots[i].cnt <= cnt_dec(slots[i].cnt);
    end
    if (push) slots[wr_ptr] <= push_entry;
  end

  assign head_rdata = slots[rd_ptr].rdata;
  assign head_ready = (count != '0) && (slots[rd_ptr].cnt == 4'd0);
  assign full       = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/data_resp_stall.sv
// Memory end of the core data port with programmable grant stalls and response latency.
// Define DATA_RESP_LFSR_STALL_EN to randomise wait states (LFSR-masked gnt_stall_i).
module data_resp_stall
  import data_resp_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 14,
  parameter int DEPTH          = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  data_resp_if.slave             bus,
  input  logic [3:0]             gnt_stall_i,
  input  logic [3:0]             rvalid_lat_i,
  output logic [$clog2(DEPTH):0] outstanding_o
);

  logic [31:0]               mem [2**MEM_ADDR_WIDTH];
  logic [MEM_ADDR_WIDTH-1:0] idx;
  logic [3:0]                stall_cnt;
  logic [3:0]                stall_load;
  logic                      accept;
  logic                      bypass;
  logic                      push;
  logic                      head_ready;
  logic                      fifo_full;
  logic [31:0]               head_rdata;
  logic [$clog2(DEPTH):0]    count;
  resp_entry_t               new_entry;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic                      unused_addr;

  assign idx         = bus.addr_i[MEM_ADDR_WIDTH+1:2];
  assign unused_addr = ^{bus.addr_i[31:MEM_ADDR_WIDTH+2], bus.addr_i[1:0]};

`ifdef DATA_RESP_LFSR_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign stall_load = lfsr[3:0] & gnt_stall_i;
`else
  assign stall_load = gnt_stall_i;
`endif

  assign bus.gnt_o = bus.req_i && !rst_i && (stall_cnt == 4'd0) && !fifo_full;
  assign accept    = bus.req_i && bus.gnt_o;

  // Reloads whenever the bus is idle or a transaction lands, so each request waits afresh.
  always_ff @(posedge clk_i) begin
    if (rst_i || !bus.req_i || accept) stall_cnt <= stall_load;
    else if (stall_cnt != 4'd0)        stall_cnt <= stall_cnt - 4'd1;
  end

  // RAM contents survive reset so a bench can reset the core without reloading memory.
  always_ff @(posedge clk_i) begin
    if (accept && bus.we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.be_i[b]) mem[idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
      end
    end
  end

  // The stored countdown is already advanced for the acceptance cycle, so an entry with
  // latency L pops L cycles after it is written and responds L+1 cycles after acceptance.
  assign new_entry.rdata = bus.we_i ? 32'd0 : mem[idx];
  assign new_entry.cnt   = cnt_dec(rvalid_lat_i);

  // Zero-latency transaction into an empty FIFO goes straight to the output register.
  assign bypass = accept && (count == '0) && (rvalid_lat_i == 4'd0);
  assign push   = accept && !bypass;

  data_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .push_entry (new_entry),
    .pop        (head_ready),
    .head_rdata (head_rdata),
    .head_ready (head_ready),
    .full       (fifo_full),
    .count      (count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= head_ready || bypass;
      rdata_q  <= head_ready ? head_rdata : (bypass ? new_entry.rdata : 32'd0);
    end
  end

  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign outstanding_o = count;

endmodule
